// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/load-store memory port arbiter.
// Combinational-only package: no latency, no flow control of its own.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/arb_prio2.sv
// Two-requester priority select; fixed winner on ties, or alternating winner with MEM_ARB_RR_EN.
// Combinational grant in the request cycle; a requester not granted simply keeps its request up.
module arb_prio2
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst_b,
`endif
  input  logic [1:0] req,
  input  owner_e     prio,
  output logic [1:0] gnt
);

  owner_e tie_win;

`ifdef MEM_ARB_RR_EN
  // prio is the owner treated as having gone last out of reset, so the other side wins the first tie
  owner_e last_q;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      last_q <= prio;
    end else if (|gnt) begin
      last_q <= gnt[OWN_D] ? OWN_D : OWN_IF;
    end
  end

  assign tie_win = (last_q == OWN_D) ? OWN_IF : OWN_D;
`else
  assign tie_win = prio;
`endif

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt          = 2'b00;
      gnt[tie_win] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; grant to response is MEM_LATENCY+2 cycles.
// Requesters hold req until gnt; one transaction in flight; MEM_ARB_RR_EN selects round-robin ties.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            halted,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [3:0]      d_be,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  owner_e            owner_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   if_rdata_q;
  logic [XLEN-1:0]   d_rdata_q;
  logic              can_grant;
  logic              rdata_cycle;
  logic [1:0]        req;
  logic [1:0]        gnt;

  // Memory is word addressed; the byte offset only matters through the lane enables.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{if_addr[1:0], d_addr[1:0]};

  assign can_grant   = !rst_b && !halted && (state_q == IDLE || state_q == RESP);
  assign req         = {d_req, if_req} & {2{can_grant}};
  assign rdata_cycle = (state_q == WAIT) && (cnt_q == CNT_W'(1));

  arb_prio2 u_prio (
`ifdef MEM_ARB_RR_EN
    .clk   (clk),
    .rst_b (rst_b),
`endif
    .req   (req),
    .prio  (OWN_D),
    .gnt   (gnt)
  );

  always_comb begin
    state_d   = state_q;
    if_gnt    = gnt[OWN_IF];
    d_gnt     = gnt[OWN_D];
    mem_req   = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|gnt) state_d = ISSUE;
      end
      ISSUE: begin
        mem_req = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (rdata_cycle) state_d = RESP;
      end
      RESP: begin
        if_rvalid = (owner_q == OWN_IF);
        d_rvalid  = (owner_q == OWN_D);
        state_d   = (|gnt) ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (gnt[OWN_D]) begin
        owner_q <= OWN_D;
        we_q    <= d_we;
        be_q    <= d_be;
        addr_q  <= {d_addr[XLEN-1:2], 2'b00};
        wdata_q <= d_wdata;
      end else if (gnt[OWN_IF]) begin
        owner_q <= OWN_IF;
        we_q    <= 1'b0;
        be_q    <= BE_WORD;
        addr_q  <= {if_addr[XLEN-1:2], 2'b00};
        wdata_q <= '0;
      end
      if (state_q == ISSUE) begin
        cnt_q <= CNT_W'(MEM_LATENCY);
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 1'b1;
      end
      // Stores complete without touching the owner's last loaded word.
      if (rdata_cycle && !we_q) begin
        if (owner_q == OWN_D) d_rdata_q  <= mem_rdata;
        else                  if_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a transaction-level arbitration model.
// Honours MEM_ARB_RR_EN the same way as the design.
module tb_mem_port_arbiter;

  localparam int L = 2;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rsp_t;

  logic        clk;
  logic        rst_b;
  logic        halted;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  logic        g_if, g_d;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  mem_exp_t    mem_exp[$];
  rsp_t        if_exp[$];
  rsp_t        d_exp[$];
  rsp_t        rd_q[$];

  mem_port_arbiter #(.MEM_LATENCY(L), .XLEN(32)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .halted    (halted),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte lane i covers bits 31-8i down to 24-8i.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[31-8*i -: 8] = wd[31-8*i -: 8];
    end
    return r;
  endfunction

  // Memory read-data driver: data appears exactly L cycles after the strobe, noise otherwise.
  initial begin
    cyc       = 0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (rd_q.size() != 0 && rd_q[0].cyc < cyc) void'(rd_q.pop_front());
      if (rd_q.size() != 0 && rd_q[0].cyc == cyc) mem_rdata = rd_q.pop_front().data;
      else mem_rdata = $urandom;
    end
  end

  // Memory array model reacting to the DUT strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_b && mem_req) begin
        if (mem_we) begin
          mem[mem_addr[5:2]] = merge(mem[mem_addr[5:2]], mem_wdata, mem_be);
        end else begin
          rd_q.push_back('{cyc: cyc + L, data: mem[mem_addr[5:2]]});
        end
      end
    end
  end

  // Reference model: arbitration decision per cycle plus expected transactions.
  initial begin
    int          free_at;
    logic [31:0] exp_d_last;
    logic        e_if, e_d;
    mem_exp_t    m;
`ifdef MEM_ARB_RR_EN
    logic        last_d;
    last_d = 1'b1;
`endif
    free_at    = 0;
    exp_d_last = '0;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        mem_exp.delete();
        if_exp.delete();
        d_exp.delete();
        free_at    = cyc + 1;
        exp_d_last = '0;
`ifdef MEM_ARB_RR_EN
        last_d = 1'b1;
`endif
      end else begin
        e_if = 1'b0;
        e_d  = 1'b0;
        if (!halted && cyc >= free_at) begin
          if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            if (last_d) e_if = 1'b1;
            else        e_d  = 1'b1;
`else
            e_d = 1'b1;
`endif
          end else begin
            e_if = if_req;
            e_d  = d_req;
          end
        end
        checks++;
        if ({if_gnt, d_gnt} !== {e_if, e_d}) begin
          errors++;
          $display("FAIL grant cyc=%0d got if_gnt/d_gnt=%b%b expected %b%b", cyc, if_gnt, d_gnt,
                   e_if, e_d);
        end
        if (e_if || e_d) begin
          free_at = cyc + 2 + L;
`ifdef MEM_ARB_RR_EN
          last_d = e_d;
`endif
          m.cyc = cyc + 1;
          if (e_d) begin
            m.addr  = {d_addr[31:2], 2'b00};
            m.we    = d_we;
            m.be    = d_be;
            m.wdata = d_wdata;
            if (d_we) ref_mem[d_addr[5:2]] = merge(ref_mem[d_addr[5:2]], d_wdata, d_be);
            else      exp_d_last = ref_mem[d_addr[5:2]];
            d_exp.push_back('{cyc: cyc + 2 + L, data: exp_d_last});
          end else begin
            m.addr  = {if_addr[31:2], 2'b00};
            m.we    = 1'b0;
            m.be    = 4'b1111;
            m.wdata = '0;
            if_exp.push_back('{cyc: cyc + 2 + L, data: ref_mem[if_addr[5:2]]});
          end
          mem_exp.push_back(m);
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a strobe or a response.
  initial begin
    mem_exp_t m;
    rsp_t     r;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        if (mem_req) begin
          checks++;
          if (mem_exp.size() == 0) begin
            errors++;
            $display("FAIL mem_req unexpected cyc=%0d addr=%h", cyc, mem_addr);
          end else begin
            m = mem_exp.pop_front();
            if (cyc != m.cyc || mem_addr !== m.addr || mem_we !== m.we || mem_be !== m.be ||
                (m.we && mem_wdata !== m.wdata)) begin
              errors++;
              $display("FAIL mem_fields got cyc=%0d addr=%h we=%b be=%b wd=%h expected cyc=%0d addr=%h we=%b be=%b wd=%h",
                       cyc, mem_addr, mem_we, mem_be, mem_wdata, m.cyc, m.addr, m.we, m.be, m.wdata);
            end
          end
        end
        if (if_rvalid) begin
          checks++;
          if (if_exp.size() == 0) begin
            errors++;
            $display("FAIL if_rvalid unexpected cyc=%0d rdata=%h", cyc, if_rdata);
          end else begin
            r = if_exp.pop_front();
            if (cyc != r.cyc || if_rdata !== r.data) begin
              errors++;
              $display("FAIL if_rsp got cyc=%0d rdata=%h expected cyc=%0d rdata=%h", cyc, if_rdata,
                       r.cyc, r.data);
            end
          end
        end
        if (d_rvalid) begin
          checks++;
          if (d_exp.size() == 0) begin
            errors++;
            $display("FAIL d_rvalid unexpected cyc=%0d rdata=%h", cyc, d_rdata);
          end else begin
            r = d_exp.pop_front();
            if (cyc != r.cyc || d_rdata !== r.data) begin
              errors++;
              $display("FAIL d_rsp got cyc=%0d rdata=%h expected cyc=%0d rdata=%h", cyc, d_rdata,
                       r.cyc, r.data);
            end
          end
        end
        while (mem_exp.size() != 0 && mem_exp[0].cyc < cyc) begin
          checks++; errors++;
          $display("FAIL mem_req missing got none expected at cyc=%0d", mem_exp.pop_front().cyc);
        end
        while (if_exp.size() != 0 && if_exp[0].cyc < cyc) begin
          checks++; errors++;
          $display("FAIL if_rvalid missing got none expected at cyc=%0d", if_exp.pop_front().cyc);
        end
        while (d_exp.size() != 0 && d_exp[0].cyc < cyc) begin
          checks++; errors++;
          $display("FAIL d_rvalid missing got none expected at cyc=%0d", d_exp.pop_front().cyc);
        end
      end
    end
  end

  // One cycle of stimulus: observe grants mid-cycle, retire granted requests after the edge.
  task automatic tick();
    @(negedge clk);
    g_if = if_gnt;
    g_d  = d_gnt;
    @(posedge clk);
    #1;
    if (g_if) if_req = 1'b0;
    if (g_d)  d_req  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    tick();
    while ((if_req || d_req || mem_exp.size() != 0 || if_exp.size() != 0 || d_exp.size() != 0)
           && n < 200) begin
      tick();
      n++;
    end
    repeat (2) tick();
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s drain got %0d cycles expected under 200", name, n);
    end
  endtask

  task automatic check_zero(input string name);
    logic [137:0] got;
    @(negedge clk);
    got = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s outputs got %h expected 0", name, got);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic raise_load(input logic [31:0] a);
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_be   = 4'hF;
    d_addr = a;
  endtask

  initial begin
    int n;
    rst_b = 1'b1; halted = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    g_if = 1'b0; g_d = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[1]     = 32'hDEADBEEF;
    ref_mem[1] = 32'hDEADBEEF;

    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
    check_zero("reset_values");

    if_addr = 32'h0000_0006; if_req = 1'b1;
    drain("single_fetch");

    d_addr = 32'h10; d_we = 1'b1; d_be = 4'b0001; d_wdata = 32'h0000_00AB; d_req = 1'b1;
    drain("byte_store");

    raise_load(32'h4);
    drain("load");

    d_addr = 32'h10; d_we = 1'b1; d_be = 4'b0010; d_wdata = $urandom; d_req = 1'b1;
    drain("store_keeps_rdata");

    for (int i = 0; i < 24; i++) begin
      if (!if_req) begin if_req = 1'b1; if_addr = $urandom; end
      if (!d_req) raise_load($urandom);
      tick();
    end
    drain("ties");

    halted = 1'b1;
    raise_load($urandom);
    repeat (5) tick();
    halted = 1'b0;
    drain("halted");

    for (int i = 0; i < 12; i++) begin
      if (!d_req) raise_load($urandom);
      tick();
    end
    drain("back_to_back");

    raise_load(32'h4);
    n = 0;
    g_d = 1'b0;
    while (!g_d && n < 20) begin tick(); n++; end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL reset_wait grant got none expected within 20 cycles");
    end
    tick();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    check_zero("reset_mid_wait");
    repeat (8) tick();

    for (int i = 0; i < 3000; i++) begin
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end else if (if_req && $urandom_range(0, 31) == 0) begin
        if_req = 1'b0;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end else if (d_req && $urandom_range(0, 31) == 0) begin
        d_req = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) halted = ~halted;
      tick();
    end
    if_req = 1'b0; d_req = 1'b0; halted = 1'b0;
    drain("random");

    checks++;
    if (mem_exp.size() + if_exp.size() + d_exp.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d pending expected 0",
               mem_exp.size() + if_exp.size() + d_exp.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got no finish expected end of test");
    $fatal(1, "timeout");
  end

endmodule
